// File: rtl/simon_pad.sv
// Player-side front end for Simon: synchronizes/debounces the four colour buttons,
// encodes one accepted press per player turn, and drives the lamps. Option macro: SIMON_PAD_ECHO_EN.
`default_nettype none

module simon_pad #(
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       simonTurn,
    input  logic [1:0] simonNum,
    input  logic       simonPressed,
    input  logic       gameOver,
    output logic [1:0] playerNum,
    output logic       playerPressed,
    output logic [3:0] lamp,
    output logic       multiPress
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_REL
    } state_t;

    state_t           r_state;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_code;
    logic [1:0]       r_player_num;
    logic             r_pressed;
    logic             r_multi;
    logic [3:0]       r_lamp;

    logic             w_en;
    logic             w_none;
    logic             w_onehot;
    logic [1:0]       w_code;
    logic [3:0]       w_hot_latched;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_accept;

    // Two-flop synchronizer for the asynchronous buttons.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_en          = !simonTurn && !gameOver;
    assign w_none        = (r_sync2 == 4'b0000);
    assign w_onehot      = !w_none && ((r_sync2 & (r_sync2 - 4'd1)) == 4'b0000);
    assign w_hot_latched = 4'(4'b0001 << r_code);
    assign w_cnt_inc     = r_cnt + CNT_W'(1);

    always_comb begin
        w_code = 2'd0;
        case (r_sync2)
            4'b0010: w_code = 2'd1;
            4'b0100: w_code = 2'd2;
            4'b1000: w_code = 2'd3;
            default: w_code = 2'd0;
        endcase
    end

    // A single-cycle debounce window accepts straight from IDLE.
    assign w_accept = ((r_state == ST_ARM) && w_en && (r_sync2 == w_hot_latched)
                       && (w_cnt_inc == LAST))
                   || ((r_state == ST_IDLE) && w_onehot && w_en && (LAST == '0));

    // Press/release FSM with registered pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_code       <= 2'd0;
            r_player_num <= 2'd0;
            r_pressed    <= 1'b0;
            r_multi      <= 1'b0;
        end else begin
            r_pressed <= 1'b0;
            r_multi   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_onehot) begin
                        if (w_accept) begin
                            r_player_num <= w_code;
                            r_pressed    <= 1'b1;
                            r_state      <= ST_WAIT_REL;
                        end else if (w_en) begin
                            r_code  <= w_code;
                            r_state <= ST_ARM;
                        end else begin
                            r_state <= ST_WAIT_REL;
                        end
                    end else if (!w_none) begin
                        r_multi <= 1'b1;
                        r_state <= ST_WAIT_REL;
                    end
                end
                ST_ARM: begin
                    if (!w_en || (r_sync2 != w_hot_latched)) begin
                        r_cnt   <= '0;
                        r_state <= w_none ? ST_IDLE : ST_WAIT_REL;
                    end else if (w_accept) begin
                        r_cnt        <= '0;
                        r_player_num <= r_code;
                        r_pressed    <= 1'b1;
                        r_state      <= ST_WAIT_REL;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_WAIT_REL: begin
                    if (!w_none) begin
                        r_cnt <= '0;
                    end else if ((LAST == '0) || (w_cnt_inc == LAST)) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SIMON_PAD_ECHO_EN
    logic r_echo;

    // Echo flag: set by an accepted press, held while the button stays down.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_echo <= 1'b0;
        end else if (w_accept) begin
            r_echo <= 1'b1;
        end else if (w_none || (r_state != ST_WAIT_REL)) begin
            r_echo <= 1'b0;
        end
    end
`endif

    // Lamp driver: game-over floods all lamps, otherwise the core's strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lamp <= 4'b0000;
        end else if (gameOver) begin
            r_lamp <= 4'b1111;
        end else if (simonTurn && simonPressed) begin
            r_lamp <= 4'(4'b0001 << simonNum);
`ifdef SIMON_PAD_ECHO_EN
        end else if (!simonTurn && r_echo && (r_state == ST_WAIT_REL)) begin
            r_lamp <= 4'(4'b0001 << r_player_num);
`endif
        end else begin
            r_lamp <= 4'b0000;
        end
    end

    assign playerNum     = r_player_num;
    assign playerPressed = r_pressed;
    assign multiPress    = r_multi;
    assign lamp          = r_lamp;

endmodule

`default_nettype wire
